// File: rtl/ps2_kb_fifo_pkg.sv
// Shared types and constants for the PS/2 keyboard front end.
package ps2_pkg;
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_state_t;

    localparam int PS2_FRAME_BITS = 11;
    localparam int PS2_DATA_BITS  = 8;
endpackage

// File: rtl/ps2_kb_fifo_if.sv
// Keyboard bus: raw PS/2 lines in, FIFO head and status out to the cpu MMIO.
interface ps2_kb_fifo_if #(parameter int DATA_WIDTH = 8);
    logic                  ps2_clk;
    logic                  ps2_data;
    logic                  sig_rd_kb;
    logic [DATA_WIDTH-1:0] kb_rdata;
    logic                  kb_ready;
    logic                  kb_overflow;
    logic                  kb_frame_err;

    modport master (output ps2_clk, ps2_data, sig_rd_kb,
                    input  kb_rdata, kb_ready, kb_overflow, kb_frame_err);
    modport slave  (input  ps2_clk, ps2_data, sig_rd_kb,
                    output kb_rdata, kb_ready, kb_overflow, kb_frame_err);
endinterface

// File: rtl/ps2_kb_fifo_rx.sv
// PS/2 frame receiver: synchronisers, falling-edge detect, frame FSM.
// Define PS2_KB_TIMEOUT_EN to abort partial frames after TIMEOUT_CYCLES idle cycles.
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int DATA_WIDTH     = PS2_DATA_BITS,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ps2Clk,
    input  logic                  ps2Data,
    output logic                  rxValid,
    output logic [DATA_WIDTH-1:0] rxByte,
    output logic                  frameErr
);
    localparam int CW = $clog2(DATA_WIDTH);

    if (TIMEOUT_CYCLES < 2) begin : gChk
        $error("TIMEOUT_CYCLES must be >= 2");
    end

    logic [1:0]            clkSync, datSync;
    logic                  clkHist;
    logic                  fe, bitIn, frameOk, tmo;
    logic [CW-1:0]         cnt;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  parBit;
    ps2_state_t            state, nextState;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clkSync <= 2'b11;
            datSync <= 2'b11;
            clkHist <= 1'b1;
        end else begin
            clkSync <= {clkSync[0], ps2Clk};
            datSync <= {datSync[0], ps2Data};
            clkHist <= clkSync[1];
        end
    end

    assign fe      = clkHist & ~clkSync[1];
    assign bitIn   = datSync[1];
    assign frameOk = bitIn & (^{shreg, parBit});

`ifdef PS2_KB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmoCnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                tmoCnt <= '0;
        else if (fe)             tmoCnt <= '0;
        else if (state != IDLE)  tmoCnt <= tmoCnt + 1'b1;
        else                     tmoCnt <= '0;
    end

    // an edge arriving on the expiry cycle keeps the frame alive
    assign tmo = (state != IDLE) && !fe && (tmoCnt == TW'(TIMEOUT_CYCLES - 1));
`else
    assign tmo = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= nextState;
    end

    always_comb begin
        nextState = state;
        if (tmo) nextState = IDLE;
        else if (fe) begin
            unique case (state)
                IDLE:    if (!bitIn) nextState = DATA;
                DATA:    if (cnt == CW'(DATA_WIDTH - 1)) nextState = PARITY;
                PARITY:  nextState = STOP;
                STOP:    nextState = IDLE;
                default: nextState = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt    <= '0;
            shreg  <= '0;
            parBit <= 1'b0;
        end else if (fe) begin
            if (state == IDLE) cnt <= '0;
            if (state == DATA) begin
                shreg[cnt] <= bitIn;
                cnt        <= cnt + 1'b1;
            end
            if (state == PARITY) parBit <= bitIn;
        end
    end

    always_comb begin
        rxValid  = 1'b0;
        frameErr = tmo;
        if (fe && state == STOP) begin
            rxValid  = frameOk;
            frameErr = !frameOk;
        end
    end

    assign rxByte = shreg;
endmodule

// File: rtl/ps2_kb_fifo.sv
// PS/2 keyboard front end: frame receiver feeding a fall-through scancode FIFO.
// Optional partial-frame timeout enabled by PS2_KB_TIMEOUT_EN.
module ps2_kb_fifo
    import ps2_pkg::*;
#(
    parameter int DATA_WIDTH     = PS2_DATA_BITS,
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic          clk,
    input  logic          rst,
    ps2_kb_fifo_if.slave  bus
);
    localparam int AW = $clog2(FIFO_DEPTH);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : gChk
        $error("FIFO_DEPTH must be a power of two >= 2");
    end

    logic                  rxValid;
    logic [DATA_WIDTH-1:0] rxByte;
    logic [AW:0]           rdPtr, wrPtr;
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic                  empty, full, push, pop, overflow;

    ps2_rx #(.DATA_WIDTH(DATA_WIDTH), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) uRx (
        .clk      (clk),
        .rst      (rst),
        .ps2Clk   (bus.ps2_clk),
        .ps2Data  (bus.ps2_data),
        .rxValid  (rxValid),
        .rxByte   (rxByte),
        .frameErr (bus.kb_frame_err)
    );

    assign empty = (rdPtr == wrPtr);
    assign full  = (rdPtr[AW] != wrPtr[AW]) && (rdPtr[AW-1:0] == wrPtr[AW-1:0]);
    assign pop   = bus.sig_rd_kb && !empty;
    // a pop in the same cycle frees the slot, so a full FIFO still accepts
    assign push  = rxValid && (!full || pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdPtr    <= '0;
            wrPtr    <= '0;
            overflow <= 1'b0;
        end else begin
            if (pop)  rdPtr <= rdPtr + 1'b1;
            if (push) wrPtr <= wrPtr + 1'b1;
            if (rxValid && !push) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wrPtr[AW-1:0]] <= rxByte;
    end

    assign bus.kb_rdata    = empty ? '0 : mem[rdPtr[AW-1:0]];
    assign bus.kb_ready    = !empty;
    assign bus.kb_overflow = overflow;
endmodule

// File: tb/tb_ps2_kb_fifo.sv
// Self-checking bench for ps2_kb_fifo: vector table, corner sequences, random traffic vs queue model.
module tb_ps2_kb_fifo;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   errPulses = 0;
    logic [7:0] model[$];
    bit   modelOvf;

    ps2_kb_fifo_if #(.DATA_WIDTH(8)) bus ();

    ps2_kb_fifo #(.DATA_WIDTH(8), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(100)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (bus.kb_frame_err === 1'b1) errPulses++;

    typedef struct {
        logic [7:0] data;
        bit         parBad;
        bit         stopBad;
        bit         expReady;
        int         expErr;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic sendBit(input logic b);
        bus.ps2_data = b;
        repeat (3) @(posedge clk);
        #1 bus.ps2_clk = 1'b0;
        repeat (5) @(posedge clk);
        #1 bus.ps2_clk = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    // mode 0: plain; 1: latency check on empty FIFO; 2: pop in the stop-edge cycle;
    // 3: sig_rd_kb already held high, byte appears then is popped next cycle
    task automatic sendFrame(input logic [7:0] d, input bit parBad, input bit stopBad, input int mode);
        logic par;
        par = ~(^d) ^ parBad;
        sendBit(1'b0);
        for (int i = 0; i < 8; i++) sendBit(d[i]);
        sendBit(par);
        bus.ps2_data = ~stopBad;
        repeat (3) @(posedge clk);
        #1 bus.ps2_clk = 1'b0;
        case (mode)
            1: begin
                repeat (2) @(posedge clk);
                #1 check("lat_pre_ready", bus.kb_ready, 0);
                @(posedge clk);
                #1 check("lat_post_ready", bus.kb_ready, !(parBad || stopBad));
                repeat (2) @(posedge clk);
            end
            2: begin
                repeat (2) @(posedge clk);
                #1 bus.sig_rd_kb = 1'b1;
                @(posedge clk);
                #1 bus.sig_rd_kb = 1'b0;
                repeat (2) @(posedge clk);
            end
            3: begin
                repeat (3) @(posedge clk);
                #1 check("held_ready", bus.kb_ready, 1);
                check("held_rdata", bus.kb_rdata, d);
                @(posedge clk);
                #1 check("held_popped", bus.kb_ready, 0);
                @(posedge clk);
            end
            default: repeat (5) @(posedge clk);
        endcase
        #1 bus.ps2_clk = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic popOne(input string name);
        logic [7:0] exp;
        exp = (model.size() > 0) ? model[0] : 8'h00;
        check({name, "_rdata"}, bus.kb_rdata, exp);
        check({name, "_ready"}, bus.kb_ready, model.size() > 0);
        bus.sig_rd_kb = 1'b1;
        @(posedge clk);
        #1 bus.sig_rd_kb = 1'b0;
        if (model.size() > 0) void'(model.pop_front());
    endtask

    task automatic modelPush(input logic [7:0] d);
        if (model.size() < DEPTH) model.push_back(d);
        else modelOvf = 1'b1;
    endtask

    task automatic doReset();
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        model.delete();
        modelOvf = 1'b0;
    endtask

    vec_t vecs[7];

    initial begin
        int e0;
        bus.ps2_clk   = 1'b1;
        bus.ps2_data  = 1'b1;
        bus.sig_rd_kb = 1'b0;
        modelOvf      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", bus.kb_ready, 0);
        check("rst_rdata", bus.kb_rdata, 0);
        check("rst_ovf", bus.kb_overflow, 0);
        check("rst_err", bus.kb_frame_err, 0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        vecs[0] = '{8'h1C, 1'b0, 1'b0, 1'b1, 0};
        vecs[1] = '{8'hF0, 1'b1, 1'b0, 1'b0, 1};
        vecs[2] = '{8'h1C, 1'b0, 1'b0, 1'b1, 0};
        vecs[3] = '{8'h00, 1'b0, 1'b0, 1'b1, 0};
        vecs[4] = '{8'hFF, 1'b0, 1'b0, 1'b1, 0};
        vecs[5] = '{8'h5A, 1'b0, 1'b1, 1'b0, 1};
        vecs[6] = '{8'hAA, 1'b0, 1'b0, 1'b1, 0};
        foreach (vecs[i]) begin
            e0 = errPulses;
            sendFrame(vecs[i].data, vecs[i].parBad, vecs[i].stopBad, 1);
            check("vec_ready", bus.kb_ready, vecs[i].expReady);
            check("vec_rdata", bus.kb_rdata, vecs[i].expReady ? vecs[i].data : 8'h00);
            check("vec_errs", errPulses - e0, vecs[i].expErr);
            if (vecs[i].expReady) model.push_back(vecs[i].data);
            popOne("vec_pop");
            check("vec_empty", bus.kb_ready, 0);
        end

        // nine bytes into eight slots: last one dropped, order preserved
        for (int i = 1; i <= 9; i++) begin
            sendFrame(8'(i), 1'b0, 1'b0, 0);
            modelPush(8'(i));
        end
        check("ovf_set", bus.kb_overflow, 1);
        for (int i = 0; i < 8; i++) popOne("ovf_pop");
        check("ovf_empty", bus.kb_ready, 0);
        check("ovf_sticky", bus.kb_overflow, 1);

        // reset in the middle of a frame with data pending
        sendFrame(8'h33, 1'b0, 1'b0, 0);
        sendBit(1'b0);
        for (int i = 0; i < 4; i++) sendBit(1'b1);
        rst = 1'b0;
        #1;
        check("mrst_ready", bus.kb_ready, 0);
        check("mrst_rdata", bus.kb_rdata, 0);
        check("mrst_ovf", bus.kb_overflow, 0);
        check("mrst_err", bus.kb_frame_err, 0);
        model.delete();
        modelOvf = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        sendFrame(8'h5A, 1'b0, 1'b0, 1);
        model.push_back(8'h5A);
        popOne("mrst_pop");

        // full FIFO with a pop landing on the push cycle
        doReset();
        for (int i = 1; i <= 8; i++) begin
            sendFrame(8'(i), 1'b0, 1'b0, 0);
            modelPush(8'(i));
        end
        check("full_noovf", bus.kb_overflow, 0);
        sendFrame(8'h0A, 1'b0, 1'b0, 2);
        void'(model.pop_front());
        model.push_back(8'h0A);
        check("simul_ovf", bus.kb_overflow, 0);
        for (int i = 0; i < 8; i++) popOne("simul_pop");
        check("simul_empty", bus.kb_ready, 0);

        // pop held while empty, then a byte arrives
        bus.sig_rd_kb = 1'b1;
        repeat (10) @(posedge clk);
        #1 check("hold_empty", bus.kb_ready, 0);
        sendFrame(8'h29, 1'b0, 1'b0, 3);
        bus.sig_rd_kb = 1'b0;
        sendFrame(8'h11, 1'b0, 1'b0, 1);
        model.push_back(8'h11);
        popOne("hold_after");

        // random traffic against the queue model
        for (int n = 0; n < 40; n++) begin
            logic [7:0] d;
            int kind, pops;
            d    = 8'($urandom);
            kind = $urandom_range(0, 5);
            e0   = errPulses;
            sendFrame(d, kind == 0, kind == 1, 0);
            if (kind > 1) modelPush(d);
            check("rnd_err", errPulses - e0, (kind < 2) ? 1 : 0);
            check("rnd_ovf", bus.kb_overflow, modelOvf);
            pops = $urandom_range(0, 2);
            for (int p = 0; p < pops; p++) popOne("rnd_pop");
        end
        while (model.size() > 0) popOne("rnd_drain");
        popOne("rnd_final");

`ifdef PS2_KB_TIMEOUT_EN
        e0 = errPulses;
        sendBit(1'b0);
        for (int i = 0; i < 3; i++) sendBit(1'b1);
        repeat (85) @(posedge clk);
        #1 check("tmo_early", errPulses - e0, 0);
        repeat (20) @(posedge clk);
        #1 check("tmo_err", errPulses - e0, 1);
        check("tmo_ready", bus.kb_ready, 0);
        sendFrame(8'h1C, 1'b0, 1'b0, 1);
        model.push_back(8'h1C);
        popOne("tmo_pop");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/ps2_kb_fifo.md
Name: ps2_kb_fifo

Overview:
PS/2 keyboard front end that feeds the cpu's keyboard MMIO inputs. It synchronises the raw PS/2 clock and data lines and deserialises 11-bit frames with a frame FSM. Valid scancodes are pushed into a first-word-fall-through FIFO. The FIFO head drives kb_rdata/kb_ready, and the head is popped by the cpu's sig_rd_kb load strobe.

Parameters:
DATA_WIDTH, 8, scancode width; equals `KbWidth.
FIFO_DEPTH, 8, FIFO entries; power of two, >= 2.
TIMEOUT_CYCLES, 50000, idle clk cycles before a partial frame is aborted (KB_TIMEOUT_EN only).

Ports:
clk  input  1  system clock; all logic is posedge clk.
rst  input  1  asynchronous reset, active-low (block in reset while rst==0).
ps2_clk  input  1  raw PS/2 clock, asynchronous to clk.
ps2_data  input  1  raw PS/2 data, asynchronous to clk.
sig_rd_kb  input  1  pop request from cpu MMIO keyboard read.
kb_rdata  output  DATA_WIDTH  FIFO head scancode; 0 when empty.
kb_ready  output  1  FIFO non-empty.
kb_overflow  output  1  sticky: a byte was dropped because the FIFO was full.
kb_frame_err  output  1  one-cycle pulse when a frame is discarded for a parity, stop-bit or timeout error.

Behaviour:
- Reset (rst==0, async): FSM=IDLE, bit counter=0, shift reg=0, rd/wr pointers=0, sync flops=1. Outputs: kb_rdata=0, kb_ready=0, kb_overflow=0, kb_frame_err=0.
- Synchronisation: 2-flop synchronisers on ps2_clk and ps2_data, plus one history flop on synced ps2_clk.
- Falling edge (fe) = history==1 && synced==0. All frame sampling happens only on fe cycles, using synced ps2_data.
- Frame FSM:
  - IDLE: on fe with data==0 (start bit), go to DATA and set cnt=0. On fe with data==1, stay in IDLE (glitch, no error).
  - DATA: on fe, shift data in LSB-first (shreg[cnt]=data) and increment cnt. After the 8th bit (cnt==7 at fe), go to PARITY.
  - PARITY: on fe, latch the parity bit and go to STOP.
  - STOP: on fe, go to IDLE. Push shreg if stop==1 and ^{shreg,parity}==1 (odd parity holds). Otherwise discard and pulse kb_frame_err for one cycle.
- Push latency: the pushed byte is visible on kb_rdata, with kb_ready=1, in the cycle after the stop-bit fe cycle.
- FIFO:
  - Pointers are log2(FIFO_DEPTH)+1 bits wide.
  - empty = (rd==wr).
  - full = MSBs differ and the lower bits are equal.
  - Pointers wrap modulo 2*FIFO_DEPTH.
- Pop: when sig_rd_kb && !empty, rd increments at the clock edge. Pop when empty is ignored, with no state change.
- Push while full:
  - Without a simultaneous pop: the byte is dropped and kb_overflow is set (sticky until reset).
  - With a simultaneous pop: both operations occur, no overflow, count unchanged.
- Push and pop when count==1: the pop takes the old head, and the new byte becomes the head the next cycle. kb_ready stays 1.
- kb_rdata is combinational from mem[rd] when non-empty, and 0 when empty.
- A frame in progress is never affected by FIFO pops.

Optional Feature:
- Macro: PS2_KB_TIMEOUT_EN.
- With the macro: a counter clears on every fe and increments every cycle while the FSM is not IDLE. When it reaches TIMEOUT_CYCLES-1, the FSM returns to IDLE, the partial frame is discarded, and kb_frame_err pulses for one cycle.
- Without the macro: no counter is built, and a partial frame waits for further edges indefinitely.

Decomposition:
- Shared package ps2_pkg:
  - enum ps2_state_t {IDLE, DATA, PARITY, STOP}.
  - PS2_FRAME_BITS=11 and PS2_DATA_BITS=8.
- Sub-module ps2_rx: synchronisers, edge detect, FSM and optional timeout. It outputs rx_valid (1-cycle) and rx_byte. It also drives kb_frame_err.
- The top holds the FIFO, pop and overflow logic.

Test Plan:
- Send frame for 0x1C (start 0, bits 0,0,1,1,1,0,0,0, parity 0, stop 1) -> one cycle after the stop fe: kb_ready=1, kb_rdata=0x1C. Then pulse sig_rd_kb for one cycle -> kb_ready=0, kb_rdata=0.
- Send 0xF0 with parity 0 (wrong; correct is 1) -> kb_frame_err pulses once, kb_ready stays 0. Then send a valid 0x1C -> received normally.
- Send 9 valid bytes 0x01..0x09 with no pops -> kb_overflow=1, and 8 pops return 0x01..0x08 in order. Send 0x0A on the 8th byte's slot while popping in the same cycle as full -> no overflow.
- Assert rst=0 mid-frame after 4 data bits -> all outputs 0 immediately. After release, a full 0x5A frame is received correctly.
- sig_rd_kb held high while empty for 10 cycles, then a 0x29 frame arrives -> 0x29 is popped the cycle after it appears, and the pointers do not underflow.
- PS2_KB_TIMEOUT_EN with TIMEOUT_CYCLES=100: stop edges after 3 data bits -> kb_frame_err pulses and the FSM is IDLE 100 cycles after the last fe. Then a valid 0x1C is received.
